// File: rtl/deadlock_mon_pkg.sv
// Shared types, default sizing and width helpers for the dataflow deadlock monitor.
package deadlock_mon_pkg;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_CHECK = 2'd1,
      S_BLOCK = 2'd2
   } state_e;

   localparam int unsigned DEF_N_AXIS        = 2;
   localparam int unsigned DEF_N_IDLE        = 12;
   localparam int unsigned DEF_N_INST        = 9;
   localparam int unsigned DEF_STABLE_CYCLES = 8;
   localparam int unsigned DEF_CNT_W         = 8;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

   // Index buses need at least one bit even for a single instance.
   function automatic int unsigned idx_width(input int unsigned n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dataflow_deadlock_detector_if.sv
// Status vectors from the dataflow chain and the deadlock verdict/diagnostics back.
interface dataflow_deadlock_detector_if #(
   parameter int unsigned N_AXIS = deadlock_mon_pkg::DEF_N_AXIS,
   parameter int unsigned N_IDLE = deadlock_mon_pkg::DEF_N_IDLE,
   parameter int unsigned N_INST = deadlock_mon_pkg::DEF_N_INST,
   parameter int unsigned CNT_W  = deadlock_mon_pkg::DEF_CNT_W
);
   localparam int unsigned IDX_W = deadlock_mon_pkg::idx_width(N_INST);

   logic [N_AXIS-1:0] axis_block_sigs;
   logic [N_IDLE-1:0] inst_idle_sigs;
   logic [N_INST-1:0] inst_block_sigs;
   logic              block;
   logic              block_sticky;
   logic [N_INST-1:0] block_mask;
   logic [IDX_W-1:0]  first_idx;
   logic [CNT_W-1:0]  event_count;

   modport master (
      output axis_block_sigs, inst_idle_sigs, inst_block_sigs,
      input  block, block_sticky, block_mask, first_idx, event_count
   );

   modport slave (
      input  axis_block_sigs, inst_idle_sigs, inst_block_sigs,
      output block, block_sticky, block_mask, first_idx, event_count
   );
endinterface

// File: rtl/dataflow_deadlock_detector_lsb_index_enc.sv
// Combinational lowest-set-bit encoder with a valid flag.
module lsb_index_enc #(
   parameter int unsigned N  = 9,
   parameter int unsigned IW = 4
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          valid
);
   // Scan from the top so the lowest set bit wins the last assignment.
   always_comb begin
      idx   = '0;
      valid = |vec;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end
endmodule

// File: rtl/dataflow_deadlock_detector.sv
// Declares a kernel deadlock once all-internal blocking persists, and latches which instances were stuck.
module dataflow_deadlock_detector
   import deadlock_mon_pkg::*;
#(
   parameter int unsigned N_AXIS        = DEF_N_AXIS,
   parameter int unsigned N_IDLE        = DEF_N_IDLE,
   parameter int unsigned N_INST        = DEF_N_INST,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input logic                        clock,
   input logic                        reset,
   dataflow_deadlock_detector_if.slave bus
);
   localparam int unsigned CNT_BITS = clog2(STABLE_CYCLES + 1);
   localparam int unsigned IDX_W    = idx_width(N_INST);

   logic [N_INST-1:0] act;
   logic [N_INST-1:0] stalled;
   logic              all_stuck;
   logic              cand;

   // External stalls on any AXIS port rule out a deadlock verdict.
   assign act       = ~bus.inst_idle_sigs[N_INST-1:0];
   assign stalled   = bus.inst_block_sigs & act;
   assign all_stuck = &(bus.inst_block_sigs | bus.inst_idle_sigs[N_INST-1:0]);
   assign cand      = (|stalled) & all_stuck & ~(|bus.axis_block_sigs);

   generate
      if (N_IDLE > N_INST) begin : g_proc_idle
         logic proc_idle_unused;
         assign proc_idle_unused = ^bus.inst_idle_sigs[N_IDLE-1:N_INST];
      end
   endgenerate

   state_e              state, state_nx;
   logic [CNT_BITS-1:0] cnt, cnt_nx;
   logic                declare;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      declare  = 1'b0;
      case (state)
         S_RUN: begin
            cnt_nx = '0;
            if (cand) begin
               if (STABLE_CYCLES == 1) begin
                  state_nx = S_BLOCK;
                  declare  = 1'b1;
               end else begin
                  state_nx = S_CHECK;
                  cnt_nx   = CNT_BITS'(1);
               end
            end
         end
         S_CHECK: begin
            if (!cand) begin
               state_nx = S_RUN;
               cnt_nx   = '0;
            end else if (cnt == CNT_BITS'(STABLE_CYCLES - 1)) begin
               state_nx = S_BLOCK;
               cnt_nx   = '0;
               declare  = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_BITS'(1);
            end
         end
         S_BLOCK: begin
            cnt_nx = '0;
            if (!cand) state_nx = S_RUN;
         end
         default: begin
            state_nx = S_RUN;
            cnt_nx   = '0;
         end
      endcase
   end

   logic [IDX_W-1:0] enc_idx;
   logic             enc_valid;

   lsb_index_enc #(
      .N  (N_INST),
      .IW (IDX_W)
   ) u_lsb_enc (
      .vec   (stalled),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   logic              block_q;
   logic              sticky_q;
   logic [N_INST-1:0] mask_q;
   logic [IDX_W-1:0]  first_q;
   logic [CNT_W-1:0]  count_q;

   // Diagnostics are captured only on the edge that enters S_BLOCK.
   always_ff @(posedge clock) begin
      if (!reset) begin
         block_q  <= 1'b0;
         sticky_q <= 1'b0;
         mask_q   <= '0;
         first_q  <= '0;
         count_q  <= '0;
      end else begin
         block_q <= (state_nx == S_BLOCK);
         if (declare) begin
            sticky_q <= 1'b1;
            mask_q   <= stalled;
            first_q  <= enc_valid ? enc_idx : '0;
            if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign bus.block        = block_q;
   assign bus.block_sticky = sticky_q;
   assign bus.block_mask   = mask_q;
   assign bus.first_idx    = first_q;
   assign bus.event_count  = count_q;

endmodule

// File: tb/tb_dataflow_deadlock_detector.sv
// Randomized and directed checks of the deadlock detector against a run-length reference model.
module tb_dataflow_deadlock_detector;
   localparam int unsigned N_AXIS = 2;
   localparam int unsigned N_IDLE = 12;
   localparam int unsigned N_INST = 9;
   localparam int unsigned STABLE = 8;
   localparam int unsigned CNT_W  = 8;

   logic clock;
   logic reset;

   dataflow_deadlock_detector_if #(
      .N_AXIS(N_AXIS), .N_IDLE(N_IDLE), .N_INST(N_INST), .CNT_W(CNT_W)
   ) bus ();

   dataflow_deadlock_detector #(
      .N_AXIS(N_AXIS), .N_IDLE(N_IDLE), .N_INST(N_INST),
      .STABLE_CYCLES(STABLE), .CNT_W(CNT_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int compared;
   int mismatched;

   // Reference: a deadlock holds while cand has been true on the last >= STABLE edges.
   int          m_run;
   logic        m_block;
   logic        m_sticky;
   logic [8:0]  m_mask;
   logic [3:0]  m_first;
   logic [7:0]  m_count;

   function automatic logic cand_of(input logic [1:0] ax, input logic [11:0] idl, input logic [8:0] blk);
      logic [8:0] stl;
      stl = blk & ~idl[8:0];
      return (stl != 0) && ((blk | idl[8:0]) == 9'h1FF) && (ax == 0);
   endfunction

   function automatic logic [3:0] lowest(input logic [8:0] v);
      for (int i = 0; i < 9; i++) if (v[i]) return 4'(i);
      return 4'd0;
   endfunction

   task automatic tick(input logic [1:0] ax, input logic [11:0] idl, input logic [8:0] blk, input logic rst_n);
      logic c;
      bus.axis_block_sigs = ax;
      bus.inst_idle_sigs  = idl;
      bus.inst_block_sigs = blk;
      reset = rst_n;
      @(posedge clock);
      if (!rst_n) begin
         m_run = 0; m_block = 0; m_sticky = 0; m_mask = 0; m_first = 0; m_count = 0;
      end else begin
         c = cand_of(ax, idl, blk);
         m_run = c ? m_run + 1 : 0;
         if (m_run == int'(STABLE)) begin
            m_sticky = 1'b1;
            m_mask   = blk & ~idl[8:0];
            m_first  = lowest(m_mask);
            if (m_count != 8'hFF) m_count = m_count + 8'd1;
         end
         m_block = (m_run >= int'(STABLE));
      end
      #1;
   endtask

   task automatic do_reset();
      tick(2'b00, 12'hFFF, 9'h000, 1'b0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(2'($urandom), 12'($urandom), 9'($urandom), 1'b0);
         compared++;
         if ({bus.block, bus.block_sticky, bus.block_mask, bus.first_idx, bus.event_count} !== 23'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got blk=%b stk=%b mask=%h idx=%0d cnt=%0d, need all 0",
                     bus.block, bus.block_sticky, bus.block_mask, bus.first_idx, bus.event_count);
         end
      end
      for (int i = 0; i < 100; i++) begin
         tick(2'b00, 12'hFFF, 9'($urandom), 1'b1);
         compared++;
         if (bus.block !== 1'b0) begin
            mismatched++;
            $display("FAIL all_idle_block cycle %0d: got %b need 0", i, bus.block);
         end
      end
   endtask

   task automatic test_all_blocked();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         tick(2'b00, 12'h000, 9'h1FF, 1'b1);
         compared++;
         if (bus.block !== (i == 8)) begin
            mismatched++;
            $display("FAIL all_blocked_block edge %0d: got %b need %b", i, bus.block, (i == 8));
         end
      end
      compared++;
      if (bus.block_mask !== 9'h1FF || bus.first_idx !== 4'd0 || bus.event_count !== 8'd1 || bus.block_sticky !== 1'b1) begin
         mismatched++;
         $display("FAIL all_blocked_diag: got mask=%h idx=%0d cnt=%0d stk=%b need 1ff 0 1 1",
                  bus.block_mask, bus.first_idx, bus.event_count, bus.block_sticky);
      end
      for (int i = 0; i < 3; i++) begin
         tick(2'b00, 12'h000, 9'h1FF, 1'b1);
         compared++;
         if (bus.block !== 1'b1 || bus.event_count !== 8'd1) begin
            mismatched++;
            $display("FAIL all_blocked_hold: got blk=%b cnt=%0d need 1 1", bus.block, bus.event_count);
         end
      end
   endtask

   task automatic test_partial();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         tick(2'b00, 12'h10F, 9'h0F0, 1'b1);
         compared++;
         if (bus.block !== (i == 8)) begin
            mismatched++;
            $display("FAIL partial_block edge %0d: got %b need %b", i, bus.block, (i == 8));
         end
      end
      compared++;
      if (bus.block_mask !== 9'h0F0 || bus.first_idx !== 4'd4 || bus.event_count !== 8'd1) begin
         mismatched++;
         $display("FAIL partial_diag: got mask=%h idx=%0d cnt=%0d need 0f0 4 1",
                  bus.block_mask, bus.first_idx, bus.event_count);
      end
   endtask

   task automatic test_axis_block();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick(2'b01, 12'h10F, 9'h0F0, 1'b1);
         compared++;
         if (bus.block !== 1'b0) begin
            mismatched++;
            $display("FAIL axis_block_block cycle %0d: got %b need 0", i, bus.block);
         end
      end
      compared++;
      if (bus.event_count !== 8'd0 || bus.block_sticky !== 1'b0) begin
         mismatched++;
         $display("FAIL axis_block_diag: got cnt=%0d stk=%b need 0 0", bus.event_count, bus.block_sticky);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int i = 0; i < 7; i++) tick(2'b00, 12'h000, 9'h1FF, 1'b1);
      tick(2'b00, 12'h000, 9'h000, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         tick(2'b00, 12'h000, 9'h1FF, 1'b1);
         compared++;
         if (bus.block !== (i == 8)) begin
            mismatched++;
            $display("FAIL glitch_block edge %0d: got %b need %b", i, bus.block, (i == 8));
         end
      end
      compared++;
      if (bus.event_count !== 8'd1) begin
         mismatched++;
         $display("FAIL glitch_count: got %0d need 1", bus.event_count);
      end
   endtask

   task automatic test_release_rearm();
      do_reset();
      for (int i = 0; i < 8; i++) tick(2'b00, 12'h000, 9'h1FF, 1'b1);
      tick(2'b00, 12'h000, 9'h1F7, 1'b1);
      compared++;
      if (bus.block !== 1'b0 || bus.block_sticky !== 1'b1 || bus.block_mask !== 9'h1FF) begin
         mismatched++;
         $display("FAIL release: got blk=%b stk=%b mask=%h need 0 1 1ff", bus.block, bus.block_sticky, bus.block_mask);
      end
      for (int i = 1; i <= 8; i++) begin
         tick(2'b00, 12'h000, 9'h1FF, 1'b1);
         compared++;
         if (bus.block !== (i == 8)) begin
            mismatched++;
            $display("FAIL rearm_block edge %0d: got %b need %b", i, bus.block, (i == 8));
         end
      end
      compared++;
      if (bus.event_count !== 8'd2) begin
         mismatched++;
         $display("FAIL rearm_count: got %0d need 2", bus.event_count);
      end
      tick(2'b00, 12'h000, 9'h1FF, 1'b0);
      compared++;
      if ({bus.block, bus.block_sticky, bus.block_mask, bus.first_idx, bus.event_count} !== 23'd0) begin
         mismatched++;
         $display("FAIL reset_in_block: got blk=%b stk=%b mask=%h idx=%0d cnt=%0d need all 0",
                  bus.block, bus.block_sticky, bus.block_mask, bus.first_idx, bus.event_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int n = 1; n <= 260; n++) begin
         for (int i = 0; i < 8; i++) tick(2'b00, 12'h000, 9'h1FF, 1'b1);
         compared++;
         if (bus.block !== 1'b1 || bus.event_count !== 8'((n > 255) ? 255 : n)) begin
            mismatched++;
            $display("FAIL saturate decl %0d: got blk=%b cnt=%0d need 1 %0d",
                     n, bus.block, bus.event_count, (n > 255) ? 255 : n);
         end
         tick(2'b10, 12'h000, 9'h1FF, 1'b1);
      end
   endtask

   task automatic test_random();
      logic [1:0]  ax;
      logic [11:0] idl;
      logic [8:0]  blk;
      logic        rst_n;
      int          seg;
      do_reset();
      for (int s = 0; s < 120; s++) begin
         blk = 9'($urandom);
         idl = 12'($urandom);
         if ($urandom_range(0, 3) != 0) idl[8:0] = ~blk | (9'($urandom) & 9'($urandom));
         ax  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         seg = $urandom_range(1, 12);
         for (int i = 0; i < seg; i++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            tick(ax, idl, blk, rst_n);
            compared++;
            if ({bus.block, bus.block_sticky, bus.block_mask, bus.first_idx, bus.event_count}
                !== {m_block, m_sticky, m_mask, m_first, m_count}) begin
               mismatched++;
               $display("FAIL random seg %0d: got blk=%b stk=%b mask=%h idx=%0d cnt=%0d need %b %b %h %0d %0d",
                        s, bus.block, bus.block_sticky, bus.block_mask, bus.first_idx, bus.event_count,
                        m_block, m_sticky, m_mask, m_first, m_count);
            end
         end
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      m_run = 0; m_block = 0; m_sticky = 0; m_mask = 0; m_first = 0; m_count = 0;
      reset = 1'b0;
      bus.axis_block_sigs = '0;
      bus.inst_idle_sigs  = '1;
      bus.inst_block_sigs = '0;
      test_reset();
      test_all_blocked();
      test_partial();
      test_axis_block();
      test_glitch();
      test_release_rearm();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/dataflow_deadlock_detector.md
Name: dataflow_deadlock_detector

Overview:
Core deadlock judge fed by the kernel-level monitor top. It consumes the per-instance idle/block vectors and the AXIS block vector gathered from the dataflow chain (castIn, conv4…conv7, castOut), and decides when the kernel is truly deadlocked. A deadlock is a persistent, all-internal blocked state. It drives the `block` flag back to the top and latches diagnostics identifying the blocked instances.

Parameters:
N_AXIS, 2, width of axis_block_sigs
N_IDLE, 12, width of inst_idle_sigs; bits [N_INST-1:0] pair with inst_block_sigs, the rest are process-level idles
N_INST, 9, width of inst_block_sigs
STABLE_CYCLES, 8, consecutive qualifying cycles before declaring deadlock (>=1)
CNT_W, 8, width of event counter

Ports:
clock  in  1  monitor clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clock)
axis_block_sigs  in  N_AXIS  1 = AXIS port stalled on external side
inst_idle_sigs  in  N_IDLE  1 = instance idle
inst_block_sigs  in  N_INST  1 = instance blocked (FIFO full/empty or done without continue)
block  out  1  deadlock currently declared
block_sticky  out  1  deadlock declared at least once since reset
block_mask  out  N_INST  blocked-and-active instances captured at declaration
first_idx  out  clog2(N_INST)  lowest set index of block_mask
event_count  out  CNT_W  number of deadlock declarations, saturating

Behaviour:
- Combinational terms, all from inputs of the current cycle:
  - act = ~inst_idle_sigs[N_INST-1:0]
  - stalled = inst_block_sigs & act
  - all_stuck = &(inst_block_sigs | inst_idle_sigs[N_INST-1:0])
  - cand = (|stalled) & all_stuck & ~(|axis_block_sigs)
- Any AXIS block means external starvation or backpressure. It never qualifies as deadlock.
- FSM states S_RUN, S_CHECK, S_BLOCK. A cnt register of clog2(STABLE_CYCLES+1) bits is held in S_CHECK.
- S_RUN:
  - cnt=0.
  - If cand and STABLE_CYCLES==1, go to S_BLOCK.
  - Else if cand, go to S_CHECK with cnt=1.
- S_CHECK:
  - If !cand, go to S_RUN with cnt=0.
  - Else if cnt==STABLE_CYCLES-1, go to S_BLOCK.
  - Else cnt++.
- S_BLOCK: stay while cand. If !cand, go to S_RUN.
- Latency: cand sampled high on STABLE_CYCLES consecutive edges sets block=1 right after the last of those edges. The first edge with cand low in S_BLOCK clears block right after that edge.
- On every S_RUN/S_CHECK -> S_BLOCK transition, at the same edge:
  - block_mask <= stalled
  - first_idx <= lowest set bit of stalled
  - block_sticky <= 1
  - event_count <= event_count+1, saturating at 2^CNT_W-1
- block_mask and first_idx hold until the next declaration.
- block is registered and equals (state==S_BLOCK).
- Any cand glitch low during S_CHECK restarts counting from zero. There is no hysteresis.
- Reset mid-operation returns to S_RUN at the next edge and clears all outputs to 0.
- Reset values: block=0, block_sticky=0, block_mask=0, first_idx=0, event_count=0.
- All instances idle gives |stalled=0, so it is never deadlock.
- Simultaneous AXIS block and internal block: cand=0, so counting restarts.
- STABLE_CYCLES=1: a declaration occurs on the first qualifying edge.

Decomposition:
- Package deadlock_mon_pkg holds:
  - the state enum {S_RUN,S_CHECK,S_BLOCK}
  - default constants N_AXIS/N_IDLE/N_INST/STABLE_CYCLES
  - a clog2 helper function
- One sub-module, lsb_index_enc: parameterised, combinational, N-bit vector in, index out, plus a valid bit. It is used to compute first_idx.

Test Plan:
- Reset held low 3 cycles with random inputs -> all outputs 0. Release with all idle -> block stays 0 for 100 cycles.
- inst_block=9'h1FF, idle[8:0]=0, axis=0 held 8 cycles -> block=1 after the 8th edge; block_mask=9'h1FF, first_idx=0, event_count=1, block_sticky=1.
- inst_block=9'h0F0, idle[8:0]=9'h10F (bits 0-3 and 8 idle), held -> block after 8 edges; block_mask=9'h0F0, first_idx=4.
- Same as the previous scenario but axis_block_sigs=2'b01 throughout -> block never asserts; event_count=0.
- Qualifying pattern for 7 cycles, 1 cycle cand low, then 8 cycles qualifying -> block asserts only after the second run's 8th edge.
- Declared block, then inst_block[3] drops for 1 cycle -> block=0 next cycle, block_sticky stays 1. Re-qualify for 8 cycles -> event_count=2. Pull reset low while in S_BLOCK -> all outputs 0 next edge.
